// File: rtl/game_pkg.sv
// Shared definitions for the pac-man game state controller: FSM encoding,
// sprite direction codes, default scoring and a small popcount helper.
package game_pkg;

  // FSM state encoding, also visible on the state output port
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_DYING    = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_WIN      = 3'd4
  } state_e;

  // One-hot sprite direction codes shared with the movement logic
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  // Default point values per scoring event
  localparam int DEF_FOOD_PTS   = 1;
  localparam int DEF_PELLET_PTS = 5;
  localparam int DEF_GHOST_PTS  = 20;

  // Default timer durations, in game ticks
  localparam int DEF_FRIGHT_TICKS = 256;
  localparam int DEF_DEATH_TICKS  = 64;

  // Number of set bits in an 8-bit ghost collision vector
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/game_state_ctrl_tick_timer.sv
// Loadable down-counter that only moves on enabled cycles. Reports when it
// is empty and when the next enabled step will empty it.
module tick_timer #(
  parameter int W        = 8,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,     // highest priority: force to zero
  input  logic load,    // reload with LOAD_VAL
  input  logic en,      // one decrement step (held at zero)
  output logic zero_o,
  output logic last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = W'(LOAD_VAL);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game state controller: tracks score, lives, remaining food and the
// frightened / death timers, and sequences IDLE/PLAY/DYING/GAMEOVER/WIN.
// Every output comes from a register; inputs only feed next-state logic.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS   = 4,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 12,
  parameter int TOTAL_FOOD   = 300,
  parameter int FOOD_PTS     = DEF_FOOD_PTS,
  parameter int PELLET_PTS   = DEF_PELLET_PTS,
  parameter int GHOST_PTS    = DEF_GHOST_PTS,
  parameter int FRIGHT_TICKS = DEF_FRIGHT_TICKS,
  parameter int DEATH_TICKS  = DEF_DEATH_TICKS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            start,
  input  logic                            food_eaten,
  input  logic                            pellet_eaten,
  input  logic [NUM_GHOSTS-1:0]           ghost_hit,
  output logic [2:0]                      state,
  output logic [2:0]                      lives_left,
  output logic [SCORE_W-1:0]              score,
  output logic [$clog2(TOTAL_FOOD+1)-1:0] food_left,
  output logic                            frightened,
  output logic [NUM_GHOSTS-1:0]           ghost_eaten,
  output logic                            respawn_req
);

  localparam int FOOD_W   = $clog2(TOTAL_FOOD + 1);
  localparam int FR_W     = $clog2(FRIGHT_TICKS + 1);
  localparam int DT_W     = $clog2(DEATH_TICKS + 1);
  // Wide enough that score plus one tick's worth of points cannot wrap
  localparam int SUM_W    = SCORE_W + 32;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e                  state_q, state_d;
  logic [2:0]              lives_q, lives_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [FOOD_W-1:0]       food_q, food_d;
  logic [NUM_GHOSTS-1:0]   ghost_eaten_q, ghost_eaten_d;
  logic                    respawn_q, respawn_d;

  // Timer controls and flags
  logic fr_clr, fr_load, fr_en, fr_zero, fr_last_unused;
  logic dt_clr, dt_load, dt_en, dt_zero, dt_last;

  // Per-tick event arithmetic
  logic                    fright_now;
  logic [NUM_GHOSTS-1:0]   ghost_credit;
  logic [7:0]              ghost_credit8;
  logic [1:0]              items;
  logic [31:0]             add_pts;
  logic [SUM_W-1:0]        score_sum;
  logic [SCORE_W-1:0]      score_sat;
  logic [FOOD_W-1:0]       food_sub;
  logic                    lethal;

  // Ghosts are edible only if the timer was running before this tick, so a
  // pellet eaten in the same tick never protects against a collision.
  assign fright_now = !fr_zero;

  // A ghost is eaten on a channel that collides while ghosts are frightened
  generate
    for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_credit
      assign ghost_credit[gi] = fright_now & ghost_hit[gi];
    end
  endgenerate

  assign ghost_credit8 = 8'(ghost_credit);
  assign lethal        = !fright_now && (|ghost_hit);

  tick_timer #(
    .W        (FR_W),
    .LOAD_VAL (FRIGHT_TICKS)
  ) u_fright_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (fr_clr),
    .load   (fr_load),
    .en     (fr_en),
    .zero_o (fr_zero),
    .last_o (fr_last_unused)
  );

  tick_timer #(
    .W        (DT_W),
    .LOAD_VAL (DEATH_TICKS)
  ) u_death_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (dt_clr),
    .load   (dt_load),
    .en     (dt_en),
    .zero_o (dt_zero),
    .last_o (dt_last)
  );

  // Saturating score and food updates for the current tick's events
  always_comb begin
    items   = {1'b0, food_eaten} + {1'b0, pellet_eaten};
    add_pts = (food_eaten   ? 32'(FOOD_PTS)   : 32'd0)
            + (pellet_eaten ? 32'(PELLET_PTS) : 32'd0)
            + 32'(GHOST_PTS) * 32'(popcount8(ghost_credit8));
    score_sum = SUM_W'(score_q) + SUM_W'(add_pts);
    if (score_sum > SUM_W'(SCORE_MAX)) begin
      score_sat = SCORE_MAX;
    end else begin
      score_sat = score_sum[SCORE_W-1:0];
    end
    if (32'(food_q) > 32'(items)) begin
      food_sub = food_q - FOOD_W'(items);
    end else begin
      food_sub = '0;
    end
  end

  // Next-state logic for the game FSM, counters and timer controls
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    food_d        = food_q;
    ghost_eaten_d = '0;
    respawn_d     = 1'b0;
    fr_clr        = 1'b0;
    fr_load       = 1'b0;
    fr_en         = 1'b0;
    dt_clr        = 1'b0;
    dt_load       = 1'b0;
    dt_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        score_d = '0;
        lives_d = 3'(LIVES);
        food_d  = FOOD_W'(TOTAL_FOOD);
        fr_clr  = 1'b1;
        dt_clr  = 1'b1;
        if (start) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          score_d       = score_sat;
          food_d        = food_sub;
          ghost_eaten_d = ghost_credit;
          if (pellet_eaten) begin
            fr_load = 1'b1;
          end else begin
            fr_en = 1'b1;
          end
          // Clearing the board wins even if a ghost was lethal this tick
          if (food_sub == '0) begin
            state_d = ST_WIN;
            fr_clr  = 1'b1;
          end else if (lethal) begin
            state_d = ST_DYING;
            fr_clr  = 1'b1;
            dt_load = 1'b1;
            if (lives_q != 3'd0) begin
              lives_d = lives_q - 3'd1;
            end
          end
        end
      end

      ST_DYING: begin
        // Frightened timer is already clear on entry and stays frozen here
        if (tick) begin
          dt_en = 1'b1;
          if (dt_last || dt_zero) begin
            dt_clr    = 1'b1;
            respawn_d = 1'b1;
            state_d   = (lives_q != 3'd0) ? ST_PLAY : ST_GAMEOVER;
          end
        end
      end

      ST_GAMEOVER, ST_WIN: begin
        fr_clr = 1'b1;
        dt_clr = 1'b1;
        if (start) begin
          state_d = ST_IDLE;
          score_d = '0;
          lives_d = 3'(LIVES);
          food_d  = FOOD_W'(TOTAL_FOOD);
        end
      end

      default: begin
        state_d = ST_IDLE;
        fr_clr  = 1'b1;
        dt_clr  = 1'b1;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lives_q       <= 3'(LIVES);
      score_q       <= '0;
      food_q        <= FOOD_W'(TOTAL_FOOD);
      ghost_eaten_q <= '0;
      respawn_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      food_q        <= food_d;
      ghost_eaten_q <= ghost_eaten_d;
      respawn_q     <= respawn_d;
    end
  end

  assign state       = state_q;
  assign lives_left  = lives_q;
  assign score       = score_q;
  assign food_left   = food_q;
  assign frightened  = fright_now;
  assign ghost_eaten = ghost_eaten_q;
  assign respawn_req = respawn_q;

endmodule
